alu: RTL and testbench
======================

# alu

16-bit combinational-core ALU with registered outputs, the execute-stage datapath block of the MIPS-style processor. It performs arithmetic, logic, compare and, optionally, shift operations on two 16-bit operands, selected by a 4-bit MIPS ALU-control opcode. It also produces carry, signed overflow and three-way compare flags. All outputs are registered, with one cycle of latency.

## Interface
- Parameters: none. The width is fixed at 16.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- x  input  16  operand A.
- y  input  16  operand B.
- out  output  16  result, registered.
- cin  input  1  carry-in for ADD, borrow-in for SUB.
- cout  output  1  carry-out, registered.
- lt  output  1  x < y, signed, registered.
- eq  output  1  x == y, registered.
- gt  output  1  x > y, signed, registered.
- v  output  1  signed overflow, registered.
- opcode  input  4  operation select.

## Operation
- 0000 AND: out = x & y.
- 0001 OR: out = x | y.
- 0010 ADD: out = x + y + cin.
  - cout = bit 16 of the 17-bit sum.
  - v = 1 when the operand signs match and the result sign differs.
- 0011 XOR: out = x ^ y.
- 0110 SUB: out = x − y − cin, computed as x + ~y + (1 − cin).
  - cout = bit 16 of that sum; 1 means no borrow.
  - v = 1 when the operand signs differ and the result sign differs from x.
- 0111 SLT: out = 16'h0001 if $signed(x) < $signed(y), else 16'h0000.
- 1100 NOR: out = ~(x | y).
- 1000 SLL: out = x << y[3:0]. Requires ALU_SHIFT_EN.
- 1001 SRL: out = x >> y[3:0], logical. Requires ALU_SHIFT_EN.
- 1010 SRA: out = $signed(x) >>> y[3:0]. Requires ALU_SHIFT_EN.
- Any other opcode: out = 0.
- cout = 0 and v = 0 for every opcode except ADD and SUB.
- Compare flags:
  - lt, eq and gt are evaluated every cycle regardless of opcode.
  - The comparison is signed, two's complement.
  - Exactly one of the three is 1.
- cin is ignored by all opcodes except ADD and SUB.

## Timing
- Inputs are sampled on the rising edge of clk; results appear on the outputs after that same edge.
- Latency is 1 cycle and throughput is one operation per cycle. There is no handshake.
- Reset: when rst = 1 at a rising edge:
  - out = 0, cout = 0, v = 0, lt = 0, gt = 0.
  - eq = 1, which keeps the flags consistent with "0 == 0".
- Reset takes priority over any operation on the same edge.
- Releasing reset: the first valid result appears one edge after rst deasserts.
- A mid-stream reset discards the operation sampled on that edge.
- Wrap-around: ADD and SUB results are truncated to 16 bits; the overflow is reported only through cout and v.
- Shift amounts use y[3:0] only; y[15:4] is ignored for shifts.

## Configuration
- Macro: ALU_SHIFT_EN.
- Defined: opcodes 1000, 1001 and 1010 perform SLL, SRL and SRA as specified above.
- Undefined: those opcodes fall into the "other opcode" case (out = 0, cout = 0, v = 0), and no shifter logic is synthesized.
- Compare flags are identical in both builds.

## Structure
- Shared package alu_pkg holds:
  - ALU_W = 16.
  - The opcode localparams: OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT, OP_NOR, OP_SLL, OP_SRL, OP_SRA.
  - Optionally an enum typedef alu_op_t over those opcodes.
- One natural sub-module, alu_addsub:
  - 17-bit adder with invert-B control.
  - Outputs sum, cout and v.
  - Shared by ADD, SUB and SLT.
- The top level holds the opcode mux, the compare logic and the output registers.

## Test plan
- Reset: rst = 1 for 2 cycles with arbitrary inputs -> out = 0, cout = 0, v = 0, lt = 0, gt = 0, eq = 1.
- ADD: x = 0002, y = 0005, cin = 0, opcode 0010 -> next cycle out = 0007, cout = 0, v = 0, lt = 1.
- SUB: x = 0003, y = 0008, cin = 0, opcode 0110 -> out = FFFB, cout = 0, v = 0, lt = 1.
- AND then SLT:
  - x = 0007, y = 0006, opcode 0000 -> out = 0006, gt = 1.
  - Then x = FFFF, y = 0001, opcode 0111 -> out = 0001, lt = 1.
- Overflow:
  - x = 7FFF, y = 0001, ADD -> out = 8000, v = 1, cout = 0.
  - x = FFFF, y = 0001, ADD, cin = 1 -> out = 0001, cout = 1, v = 0.
- Shift and illegal opcode:
  - x = 8001, y = 0004, opcode 1010 -> out = F800 with ALU_SHIFT_EN; out = 0000 without it.
  - opcode 1111 -> out = 0000 in both builds.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: datapath width and the
// MIPS ALU-control opcode encodings.
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor for ADD, SUB and SLT: a 17-bit add of a and
// (optionally inverted) b with an explicit carry-in.
import alu_pkg::*;

module alu_addsub (
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [ALU_W-1:0] sum,
  output logic             cout,
  output logic             v
);

  logic [ALU_W-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, cin};

  // Overflow against the effective second operand covers both add and subtract.
  assign v = (a[ALU_W-1] == b_eff[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: opcode mux, signed compare flags and one register stage.
// Shift opcodes (SLL/SRL/SRA) exist only when ALU_SHIFT_EN is defined.
import alu_pkg::*;

module alu (
  input  logic             clk,
  input  logic             rst,
  input  logic [ALU_W-1:0] x,
  input  logic [ALU_W-1:0] y,
  input  logic             cin,
  input  logic [3:0]       opcode,
  output logic [ALU_W-1:0] out,
  output logic             cout,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             v
);

  logic [ALU_W-1:0] as_sum;
  logic             as_cout;
  logic             as_v;
  logic             as_sub;
  logic             as_cin;

  logic [ALU_W-1:0] out_next, out_reg;
  logic             cout_next, cout_reg;
  logic             v_next, v_reg;
  logic             lt_next, lt_reg;
  logic             eq_next, eq_reg;
  logic             gt_next, gt_reg;

  // SUB takes the borrow as an inverted carry; SLT needs a plain x - y.
  always_comb begin
    as_sub = (opcode != OP_ADD);
    as_cin = 1'b1;
    if (opcode == OP_ADD)
      as_cin = cin;
    else if (opcode == OP_SUB)
      as_cin = ~cin;
  end

  alu_addsub u_addsub (
    .a    (x),
    .b    (y),
    .sub  (as_sub),
    .cin  (as_cin),
    .sum  (as_sum),
    .cout (as_cout),
    .v    (as_v)
  );

  always_comb begin
    out_next  = '0;
    cout_next = 1'b0;
    v_next    = 1'b0;
    case (opcode)
      OP_AND: out_next = x & y;
      OP_OR:  out_next = x | y;
      OP_XOR: out_next = x ^ y;
      OP_NOR: out_next = ~(x | y);
      OP_ADD, OP_SUB: begin
        out_next  = as_sum;
        cout_next = as_cout;
        v_next    = as_v;
      end
      // Sign of x - y corrected by overflow gives the true signed less-than.
      OP_SLT: out_next = {{(ALU_W-1){1'b0}}, as_sum[ALU_W-1] ^ as_v};
`ifdef ALU_SHIFT_EN
      OP_SLL: out_next = x << y[3:0];
      OP_SRL: out_next = x >> y[3:0];
      OP_SRA: out_next = $unsigned($signed(x) >>> y[3:0]);
`endif
      default: out_next = '0;
    endcase
  end

  always_comb begin
    lt_next = ($signed(x) < $signed(y));
    eq_next = (x == y);
    gt_next = !lt_next && !eq_next;
  end

  // Reset state reads as the result of comparing 0 with 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg  <= '0;
      cout_reg <= 1'b0;
      v_reg    <= 1'b0;
      lt_reg   <= 1'b0;
      eq_reg   <= 1'b1;
      gt_reg   <= 1'b0;
    end else begin
      out_reg  <= out_next;
      cout_reg <= cout_next;
      v_reg    <= v_next;
      lt_reg   <= lt_next;
      eq_reg   <= eq_next;
      gt_reg   <= gt_next;
    end
  end

  assign out  = out_reg;
  assign cout = cout_reg;
  assign v    = v_reg;
  assign lt   = lt_reg;
  assign eq   = eq_reg;
  assign gt   = gt_reg;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; expected values are hand-computed
// and packed as {out, cout, v, lt, eq, gt}.
`timescale 1ns/1ps
import alu_pkg::*;

module tb_alu;

  logic        clk;
  logic        rst;
  logic [15:0] x;
  logic [15:0] y;
  logic        cin;
  logic [3:0]  opcode;
  logic [15:0] out;
  logic        cout;
  logic        lt;
  logic        eq;
  logic        gt;
  logic        v;

  int tests_run;
  int tests_failed;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .x      (x),
    .y      (y),
    .cin    (cin),
    .opcode (opcode),
    .out    (out),
    .cout   (cout),
    .lt     (lt),
    .eq     (eq),
    .gt     (gt),
    .v      (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, let it be sampled, then settle past the edge.
  task automatic apply(input logic [15:0] xa, input logic [15:0] ya,
                       input logic ca, input logic [3:0] op);
    x = xa;
    y = ya;
    cin = ca;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] exp;
    logic [20:0] got;
    rst = 1'b1;
    x = 16'h1234;
    y = 16'h0042;
    cin = 1'b1;
    opcode = OP_ADD;
    exp = {16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      got = {out, cout, v, lt, eq, gt};
      tests_run++;
      $display("[TB] reset cycle %0d out=%h flags=%b", i, out, got[4:0]);
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL reset_%0d got=%h expected=%h", i, got, exp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    logic [15:0] xs  [8];
    logic [15:0] ys  [8];
    logic        cs  [8];
    logic [3:0]  ops [8];
    logic [20:0] exps[8];
    logic [20:0] got;
    xs   = '{16'h0002, 16'h0003, 16'h0007, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h1234, 16'h0000};
    ys   = '{16'h0005, 16'h0008, 16'h0006, 16'h0001, 16'h0001, 16'h0001, 16'h1234, 16'h0001};
    cs   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ops  = '{OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_ADD, OP_ADD, 4'b1111, 4'b0100};
    exps = '{{16'h0007, 5'b00100},
             {16'hFFFB, 5'b00100},
             {16'h0006, 5'b00001},
             {16'h0001, 5'b00100},
             {16'h8000, 5'b01001},
             {16'h0001, 5'b10100},
             {16'h0000, 5'b00010},
             {16'h0000, 5'b00100}};
    for (int i = 0; i < 8; i++) begin
      apply(xs[i], ys[i], cs[i], ops[i]);
      got = {out, cout, v, lt, eq, gt};
      tests_run++;
      $display("[TB] spec op=%b x=%h y=%h cin=%b out=%h flags=%b",
               ops[i], xs[i], ys[i], cs[i], out, got[4:0]);
      if (got !== exps[i]) begin
        tests_failed++;
        $display("[TB] FAIL spec_%0d got=%h expected=%h", i, got, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs  [7];
    logic [15:0] ys  [7];
    logic        cs  [7];
    logic [3:0]  ops [7];
    logic [20:0] exps[7];
    logic [20:0] got;
    xs   = '{16'h00F0, 16'h1234, 16'h0000, 16'h0005, 16'h8000, 16'hFFFF, 16'h8000};
    ys   = '{16'h0F00, 16'h1234, 16'h00FF, 16'h0003, 16'h0001, 16'h0F0F, 16'h8000};
    cs   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ops  = '{OP_OR, OP_XOR, OP_NOR, OP_SUB, OP_SUB, OP_AND, OP_ADD};
    exps = '{{16'h0FF0, 5'b00100},
             {16'h0000, 5'b00010},
             {16'hFF00, 5'b00100},
             {16'h0001, 5'b10001},
             {16'h7FFF, 5'b11100},
             {16'h0F0F, 5'b00100},
             {16'h0000, 5'b11010}};
    for (int i = 0; i < 7; i++) begin
      apply(xs[i], ys[i], cs[i], ops[i]);
      got = {out, cout, v, lt, eq, gt};
      tests_run++;
      $display("[TB] b2b op=%b x=%h y=%h cin=%b out=%h flags=%b",
               ops[i], xs[i], ys[i], cs[i], out, got[4:0]);
      if (got !== exps[i]) begin
        tests_failed++;
        $display("[TB] FAIL b2b_%0d got=%h expected=%h", i, got, exps[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [15:0] xs  [3];
    logic [15:0] ys  [3];
    logic [3:0]  ops [3];
    logic [15:0] outs[3];
    logic [20:0] exp;
    logic [20:0] got;
    xs  = '{16'h8001, 16'h0001, 16'h8000};
    ys  = '{16'h0004, 16'h0013, 16'h0011};
    ops = '{OP_SRA, OP_SLL, OP_SRL};
`ifdef ALU_SHIFT_EN
    outs = '{16'hF800, 16'h0008, 16'h4000};
`else
    outs = '{16'h0000, 16'h0000, 16'h0000};
`endif
    for (int i = 0; i < 3; i++) begin
      apply(xs[i], ys[i], 1'b1, ops[i]);
      exp = {outs[i], 5'b00100};
      got = {out, cout, v, lt, eq, gt};
      tests_run++;
      $display("[TB] shift op=%b x=%h y=%h out=%h flags=%b",
               ops[i], xs[i], ys[i], out, got[4:0]);
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL shift_%0d got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [20:0] got;
    logic [20:0] exp;
    apply(16'h0001, 16'h0001, 1'b0, OP_ADD);
    exp = {16'h0002, 5'b00010};
    got = {out, cout, v, lt, eq, gt};
    tests_run++;
    $display("[TB] mid pre-reset add out=%h flags=%b", out, got[4:0]);
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL mid_pre got=%h expected=%h", got, exp);
    end
    rst = 1'b1;
    apply(16'h7FFF, 16'h0001, 1'b0, OP_ADD);
    exp = {16'h0000, 5'b00010};
    got = {out, cout, v, lt, eq, gt};
    tests_run++;
    $display("[TB] mid reset out=%h flags=%b", out, got[4:0]);
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset got=%h expected=%h", got, exp);
    end
    rst = 1'b0;
    apply(16'hFFFE, 16'h0003, 1'b0, OP_ADD);
    exp = {16'h0001, 5'b10100};
    got = {out, cout, v, lt, eq, gt};
    tests_run++;
    $display("[TB] mid post-reset add out=%h flags=%b", out, got[4:0]);
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL mid_post got=%h expected=%h", got, exp);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    x = '0;
    y = '0;
    cin = 1'b0;
    opcode = OP_AND;
    test_reset();
    test_spec_vectors();
    test_back_to_back();
    test_shift();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
